// File: rtl/md_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// controller states and the default operand width.
package md_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/md_if.sv
// Request/response bundle between the execute-stage controller and md_unit.
interface md_if #(
  parameter int WIDTH = md_pkg::MD_WIDTH
);
  logic             start;
  logic [2:0]       md_ctl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, md_ctl, a, b, input busy, done, hi, lo);
  modport slave  (input start, md_ctl, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/md_negate.sv
// Conditional two's-complement negate at the port width; used both for
// operand magnitudes and for the final sign correction.
module md_negate #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);
  assign y = neg ? (~x + W'(1)) : x;
endmodule

// File: rtl/md_unit.sv
// Radix-2 iterative multiply/divide unit owning the HI/LO registers.
// One result bit per CALC cycle, then a single FIX cycle of sign correction.
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int ITER  = WIDTH
) (
  input logic clk,
  input logic rst_n,
  md_if.slave bus
);

  localparam int CNT_W = $clog2(ITER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             is_signed_q, is_signed_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             b_zero_q, b_zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [WIDTH-1:0] bmag_q, bmag_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic               op_signed;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic               res_neg;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

  assign op_signed = (bus.md_ctl == MD_MULT) || (bus.md_ctl == MD_DIV);

  md_negate #(.W(WIDTH)) u_neg_a (
    .neg (op_signed & bus.a[WIDTH-1]), .x (bus.a), .y (mag_a));
  md_negate #(.W(WIDTH)) u_neg_b (
    .neg (op_signed & bus.b[WIDTH-1]), .x (bus.b), .y (mag_b));

  // Multiply: {acc, mq} shifts right, multiplicand added when the LSB is set.
  assign mul_sum = acc_q + {1'b0, bmag_q};
  // Divide: remainder/quotient shift left, restore when the trial borrows.
  assign div_shift = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, bmag_q};

  assign res_neg = is_signed_q & (sign_a_q ^ sign_b_q);

  md_negate #(.W(2*WIDTH)) u_neg_prod (
    .neg (res_neg), .x ({acc_q[WIDTH-1:0], mq_q}), .y (prod));
  md_negate #(.W(WIDTH)) u_neg_quo (
    .neg (res_neg), .x (mq_q), .y (quo));
  // Remainder follows the dividend's sign.
  md_negate #(.W(WIDTH)) u_neg_rem (
    .neg (is_signed_q & sign_a_q), .x (acc_q[WIDTH-1:0]), .y (rem));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_div_d    = is_div_q;
    is_signed_d = is_signed_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    b_zero_d    = b_zero_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    acc_d       = acc_q;
    mq_d        = mq_q;
    bmag_d      = bmag_q;
    hi_d        = hi_q;
    lo_d        = lo_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          case (bus.md_ctl)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              is_div_d    = (bus.md_ctl == MD_DIV) || (bus.md_ctl == MD_DIVU);
              is_signed_d = op_signed;
              sign_a_d    = bus.a[WIDTH-1];
              sign_b_d    = bus.b[WIDTH-1];
              b_zero_d    = (bus.b == '0);
              acc_d       = '0;
              cnt_d       = '0;
              mq_d        = is_div_d ? mag_a : mag_b;
              bmag_d      = is_div_d ? mag_b : mag_a;
              busy_d      = 1'b1;
              state_d     = CALC;
            end
            MD_MTHI: begin
              hi_d   = bus.a;
              done_d = 1'b1;
            end
            MD_MTLO: begin
              lo_d   = bus.a;
              done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      CALC: begin
        if (is_div_q) begin
          if (!div_diff[WIDTH+1]) begin
            acc_d = div_diff[WIDTH:0];
            mq_d  = {mq_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = div_shift;
            mq_d  = {mq_q[WIDTH-2:0], 1'b0};
          end
        end else if (mq_q[0]) begin
          acc_d = {1'b0, mul_sum[WIDTH:1]};
          mq_d  = {mul_sum[0], mq_q[WIDTH-1:1]};
        end else begin
          acc_d = {1'b0, acc_q[WIDTH:1]};
          mq_d  = {acc_q[0], mq_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = FIX;
      end
      FIX: begin
        if (is_div_q) begin
          // Divide by zero leaves the dividend in HI and all-ones in LO.
          lo_d = b_zero_q ? '1 : quo;
          hi_d = rem;
        end else begin
          {hi_d, lo_d} = prod;
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      is_div_q    <= 1'b0;
      is_signed_q <= 1'b0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      b_zero_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      acc_q       <= '0;
      mq_q        <= '0;
      bmag_q      <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_div_q    <= is_div_d;
      is_signed_q <= is_signed_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      b_zero_q    <= b_zero_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      acc_q       <= acc_d;
      mq_q        <= mq_d;
      bmag_q      <= bmag_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: fixed vector table, hand-written corner sequences and
// randomized operations checked against an arithmetic reference model.
module tb_md_unit;
  import md_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  md_if #(.WIDTH(32)) bus ();

  md_unit #(.WIDTH(32), .ITER(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_total = 0;
  int n_pass  = 0;
  logic [31:0] exp_hi, exp_lo;

  typedef struct {
    logic [2:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    bit          poke;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [63:0] model(input logic [2:0] ctl, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, m;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    case (ctl)
      MD_MULT:  r = 64'(sa * sb);
      MD_MULTU: r = {32'd0, a} * {32'd0, b};
      MD_DIV: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          m = sa % sb;
          r = {m[31:0], q[31:0]};
        end
      end
      MD_DIVU: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Issues a mult/div at the current negedge and returns at the done cycle.
  task automatic do_op(input logic [2:0] ctl, input logic [31:0] ta, input logic [31:0] tb_v,
                       input logic [31:0] ehi, input logic [31:0] elo, input bit poke,
                       input string nm);
    int n, bcnt;
    bit hold_bad;
    bus.start = 1'b1; bus.md_ctl = ctl; bus.a = ta; bus.b = tb_v;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0; bcnt = 0; hold_bad = 0;
    while (!bus.done && n < 100) begin
      if (bus.busy) bcnt++;
      if (bus.hi !== exp_hi || bus.lo !== exp_lo) hold_bad = 1;
      if (poke && n == 5) begin
        bus.start = 1'b1; bus.md_ctl = MD_MTLO; bus.a = $urandom; bus.b = $urandom;
      end else bus.start = 1'b0;
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    chk({nm, " latency"}, n, 33);
    chk({nm, " busy_cycles"}, bcnt, 33);
    chk({nm, " hold"}, hold_bad, 0);
    chk({nm, " busy_at_done"}, bus.busy, 0);
    chk({nm, " hi"}, bus.hi, ehi);
    chk({nm, " lo"}, bus.lo, elo);
    exp_hi = ehi;
    exp_lo = elo;
  endtask

  task automatic do_mt(input logic [2:0] ctl, input logic [31:0] ta, input string nm);
    bus.start = 1'b1; bus.md_ctl = ctl; bus.a = ta; bus.b = $urandom;
    @(negedge clk);
    bus.start = 1'b0;
    if (ctl == MD_MTHI) exp_hi = ta; else exp_lo = ta;
    chk({nm, " done"}, bus.done, 1);
    chk({nm, " busy"}, bus.busy, 0);
    chk({nm, " hi"}, bus.hi, exp_hi);
    chk({nm, " lo"}, bus.lo, exp_lo);
    @(negedge clk);
    chk({nm, " done_width"}, bus.done, 0);
    chk({nm, " busy_after"}, bus.busy, 0);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [63:0] m;
    logic [2:0]  c;
    logic [31:0] ra, rb;
    bit          seen;

    rst_n = 1'b0;
    bus.start = 1'b0; bus.md_ctl = '0; bus.a = '0; bus.b = '0;
    exp_hi = '0; exp_lo = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", bus.busy, 0);
    chk("reset done", bus.done, 0);
    chk("reset hi", bus.hi, 0);
    chk("reset lo", bus.lo, 0);
    rst_n = 1'b1;
    @(negedge clk);

    vecs.push_back('{MD_MULT,  32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0});
    vecs.push_back('{MD_MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0});
    vecs.push_back('{MD_MULT,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0});
    vecs.push_back('{MD_DIV,   32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0});
    vecs.push_back('{MD_DIVU,  32'd100,        32'd7,         32'd2,         32'd14,        1'b0});
    vecs.push_back('{MD_DIV,   32'h1234_5678,  32'd0,         32'h1234_5678, 32'hFFFF_FFFF, 1'b0});
    vecs.push_back('{MD_DIV,   32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0});
    vecs.push_back('{MD_DIV,   32'hFFFF_FFF0,  32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b0});
    vecs.push_back('{MD_DIVU,  32'h8000_0001,  32'd0,         32'h8000_0001, 32'hFFFF_FFFF, 1'b0});
    vecs.push_back('{MD_MULT,  32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0});
    vecs.push_back('{MD_MULTU, 32'd3,          32'd5,         32'd0,         32'd15,        1'b1});
    vecs.push_back('{MD_DIV,   32'd7,          32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0});

    foreach (vecs[i])
      do_op(vecs[i].ctl, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].poke,
            $sformatf("vec%0d", i));

    do_mt(MD_MTHI, 32'hDEAD_BEEF, "mthi");
    do_mt(MD_MTLO, 32'h0BAD_F00D, "mtlo");

    // Reserved encodings must leave everything untouched.
    for (int r = 6; r < 8; r++) begin
      bus.start = 1'b1; bus.md_ctl = 3'(r); bus.a = $urandom; bus.b = $urandom;
      @(negedge clk);
      bus.start = 1'b0;
      chk("rsvd done", bus.done, 0);
      chk("rsvd busy", bus.busy, 0);
      chk("rsvd hi", bus.hi, exp_hi);
      chk("rsvd lo", bus.lo, exp_lo);
      @(negedge clk);
      chk("rsvd busy_after", bus.busy, 0);
    end

    // Reset in the middle of a multiply discards it.
    bus.start = 1'b1; bus.md_ctl = MD_MULT; bus.a = 32'd5; bus.b = 32'd6;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst busy", bus.busy, 0);
    chk("midrst done", bus.done, 0);
    chk("midrst hi", bus.hi, 0);
    chk("midrst lo", bus.lo, 0);
    exp_hi = '0; exp_lo = '0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen = 1;
    end
    chk("midrst no_done", seen, 0);
    do_op(MD_DIVU, 32'd1000, 32'd33, 32'd10, 32'd30, 1'b0, "post_rst");

    for (int k = 0; k < 30; k++) begin
      c = 3'($urandom_range(0, 9));
      ra = rnd_operand();
      rb = rnd_operand();
      if (c < 3'd4) begin
        m = model(c, ra, rb);
        do_op(c, ra, rb, m[63:32], m[31:0], 1'b0, $sformatf("rnd%0d", k));
      end else begin
        do_mt(c[0] ? MD_MTLO : MD_MTHI, ra, $sformatf("rnd_mt%0d", k));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Iterative multiply/divide unit that sits beside the ALU in the execute stage and owns the architectural HI/LO registers.
- The controller issues an operation with a start pulse, stalls on busy, and reads hi/lo after done.
- Operations: MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Radix-2 datapath; one result bit per cycle.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- ITER, 32, iteration cycles per mult/div. Must equal WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle request; sampled only when busy=0
- md_ctl  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved
- a  in  WIDTH  rs operand / dividend / multiplicand
- b  in  WIDTH  rt operand / divisor / multiplier
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse when hi/lo were updated on the preceding edge
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset: on a clk edge with rst_n=0, all registers clear.
  - hi=0, lo=0, busy=0, done=0, state=IDLE.
  - Overrides any in-flight operation, which is discarded.
- States: IDLE, CALC, FIX.
- IDLE, start=1, md_ctl MULT/MULTU/DIV/DIVU:
  - Latch the operation and the operand magnitudes. For signed ops, |x| is the two's-complement negate when x[31]=1.
  - Latch sign flags.
  - Clear the counter and accumulator.
  - Go to CALC; busy=1 from this edge.
- IDLE, start=1, MTHI/MTLO:
  - hi<=a (MTHI) or lo<=a (MTLO) on the same edge.
  - done=1 for the next cycle; busy stays 0.
- IDLE, start=1, reserved md_ctl: ignored. No state change, no done.
- start while busy=1: ignored; operands and md_ctl are not re-sampled.
- CALC: exactly ITER cycles; the counter runs 0..ITER-1.
  - Multiply: shift-add on a 64-bit {acc, multiplier}. Unsigned magnitudes are used for both signed and unsigned ops.
  - Divide: restoring division on magnitudes. Remainder register is 33 bits to hold the trial-subtract borrow.
  - When the counter reaches ITER-1, go to FIX.
- FIX: one cycle of sign correction, then write hi/lo, go to IDLE, busy<=0, done<=1.
  - Signed multiply: if sign(a)^sign(b), the 64-bit product is negated. {hi,lo} = product.
  - Signed divide:
    - lo = quotient, negated if sign(a)^sign(b).
    - hi = remainder, negated if sign(a)=1. The remainder takes the dividend's sign.
  - Unsigned ops: no correction.
- Latency:
  - Start sampled at edge E0; busy=1 from E0 through E32 (ITER+1 edges).
  - hi/lo written at edge E33; done=1 in the cycle after E33.
  - Controller may issue the next start in that same done cycle.
- Divide by zero (b=0, DIV or DIVU):
  - Full latency is still taken.
  - lo=0xFFFFFFFF, hi=a (the original signed a, uncorrected).
  - No exception signal.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (natural wrap). No flag.
- hi/lo hold their values between operations. They are unchanged during CALC/FIX until the final edge.
- Width rules: all negation is two's complement at the destination width. Product is 2*WIDTH bits.

Decomposition:
- Shared package md_pkg holds:
  - md_ctl encodings MD_MULT..MD_MTLO as localparams.
  - state encodings IDLE/CALC/FIX.
  - WIDTH default.
- One natural sub-module, md_negate: combinational conditional two's-complement negate, parameterised width. It is reused for operand magnitude and result fixup.
- The FSM and datapath stay in md_unit.

Test Plan:
- MULT a=7, b=0xFFFFFFFD (-3) -> done 33 cycles after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for exactly 33 cycles.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then MULT with same operands -> hi=0, lo=1.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 -> lo=14, hi=2.
- DIV a=0x12345678, b=0 -> lo=0xFFFFFFFF, hi=0x12345678. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0xDEADBEEF -> hi updated next edge, done one cycle, busy never high. MTLO during busy -> ignored, lo unchanged at completion.
- Start MULT, pull rst_n=0 at cycle 10 for one edge -> hi=lo=0, busy=0, done never pulses. A new DIVU issued afterwards completes correctly.
